// File: rtl/gauss5_window_ctrl_if.sv
// Stream and datapath signals of gauss5_window_ctrl.
// The slave modport is the controller's view; the master modport is the environment's view.
interface gauss5_window_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic                      s_valid;
  logic                      s_ready;
  logic [DATA_WIDTH-1:0]     s_data;
  logic                      m_valid;
  logic                      m_ready;
  logic [DATA_WIDTH-1:0]     m_data;
  logic [25*DATA_WIDTH-1:0]  window_out;
  logic [23:0]               conv_in;

  modport slave (
    input  s_valid, s_data, m_ready, conv_in,
    output s_ready, m_valid, m_data, window_out
  );

  modport master (
    output s_valid, s_data, m_ready, conv_in,
    input  s_ready, m_valid, m_data, window_out
  );
endinterface

// File: rtl/gauss5_window_ctrl.sv
// 5x5 window sequencer for an external combinational Gaussian datapath over a raster stream.
// Optional CONV_BYPASS_EN adds a 'bypass' input that outputs the window centre instead of conv_in.
module gauss5_window_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 480
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
`ifdef CONV_BYPASS_EN
  input  logic                       bypass,
`endif
  gauss5_window_ctrl_if.slave        bus,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned RowW = $clog2(IMG_H);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state_q;
  logic                   busy_q;
  logic                   frame_done_q;
  logic [ColW-1:0]        col_q;
  logic [RowW-1:0]        row_q;
  logic                   in_all_q;
  logic                   win_vld_q;
  logic                   win_last_q;
  logic                   m_valid_q;
  logic                   m_last_q;
  logic [DATA_WIDTH-1:0]  m_data_q;

  logic [DATA_WIDTH-1:0]  lb_q  [4][IMG_W];
  logic [DATA_WIDTH-1:0]  win_q [5][5];
  logic [DATA_WIDTH-1:0]  col_new [5];
  logic [DATA_WIDTH-1:0]  cap;

  logic adv;
  logic s_ready;
  logic accept;
  logic last_px;
  logic out_hs;

  function automatic logic [DATA_WIDTH-1:0] sat(input logic [23:0] v);
    logic [DATA_WIDTH-1:0] r;
    if (|v[23:DATA_WIDTH]) begin
      r = '1;
    end else begin
      r = v[DATA_WIDTH-1:0];
    end
    return r;
  endfunction

  assign adv     = !m_valid_q || bus.m_ready;
  assign s_ready = (state_q == StRun) && adv && !in_all_q;
  assign accept  = bus.s_valid && s_ready;
  assign out_hs  = m_valid_q && bus.m_ready;
  assign last_px = (row_q == RowW'(IMG_H - 1)) && (col_q == ColW'(IMG_W - 1));

  // Row 0 of the incoming column is the oldest line (four lines back).
  always_comb begin
    col_new[0] = lb_q[3][col_q];
    col_new[1] = lb_q[2][col_q];
    col_new[2] = lb_q[1][col_q];
    col_new[3] = lb_q[0][col_q];
    col_new[4] = bus.s_data;
  end

  always_comb begin
`ifdef CONV_BYPASS_EN
    cap = bypass ? win_q[2][2] : sat(bus.conv_in);
`else
    cap = sat(bus.conv_in);
`endif
  end

  always_comb begin
    bus.window_out = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        bus.window_out[(r*5+c)*DATA_WIDTH +: DATA_WIDTH] = win_q[r][c];
      end
    end
  end

  // Line buffers and window are pure data; they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_q[0][col_q] <= bus.s_data;
      for (int i = 1; i < 4; i++) begin
        lb_q[i][col_q] <= lb_q[i-1][col_q];
      end
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
        win_q[r][4] <= col_new[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      in_all_q     <= 1'b0;
      win_vld_q    <= 1'b0;
      win_last_q   <= 1'b0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_data_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          if (out_hs && m_last_q) begin
            state_q      <= StDone;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end
        end
        StDone: begin
          state_q      <= StIdle;
          frame_done_q <= 1'b0;
        end
        default: begin
          state_q      <= StIdle;
          busy_q       <= 1'b0;
          frame_done_q <= 1'b0;
        end
      endcase

      if (state_q == StIdle) begin
        col_q      <= '0;
        row_q      <= '0;
        in_all_q   <= 1'b0;
        win_vld_q  <= 1'b0;
        win_last_q <= 1'b0;
      end else if (accept) begin
        // Windows whose columns straddle a line wrap are never valid.
        win_vld_q  <= (row_q >= RowW'(4)) && (col_q >= ColW'(4));
        win_last_q <= last_px;
        if (last_px) begin
          in_all_q <= 1'b1;
        end
        if (col_q == ColW'(IMG_W - 1)) begin
          col_q <= '0;
          row_q <= (row_q == RowW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end else if (adv) begin
        win_vld_q  <= 1'b0;
        win_last_q <= 1'b0;
      end

      if (adv) begin
        m_valid_q <= win_vld_q;
        m_last_q  <= win_last_q;
        if (win_vld_q) begin
          m_data_q <= cap;
        end
      end
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_gauss5_window_ctrl.sv
// Scoreboard bench for gauss5_window_ctrl on an 8x6 frame with a behavioural datapath.
// Expected pixels are queued by the stimulus; a monitor pops them on each output handshake.
module tb_gauss5_window_ctrl;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic frame_done;
`ifdef CONV_BYPASS_EN
  logic bypass = 1'b0;
`endif

  always #5 clk = ~clk;

  gauss5_window_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  gauss5_window_ctrl #(
    .DATA_WIDTH (DW),
    .IMG_W      (W),
    .IMG_H      (H)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
`ifdef CONV_BYPASS_EN
    .bypass     (bypass),
`endif
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int          checks = 0;
  int          errors = 0;
  int          exp_q[$];
  int          fd_cnt = 0;
  int          out_in_frame = 0;
  bit          pend_done = 1'b0;
  bit          rand_ready = 1'b0;
  int          dp_mode = 0;   // 0 Gaussian, 1 window centre, 2 constant stub
  logic [23:0] stub_val = 24'h0;
  int          acc;

  function automatic int wt(input int i);
    case (i)
      0, 4:    return 1;
      1, 3:    return 4;
      default: return 6;
    endcase
  endfunction

  always_comb begin
    acc = 0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        acc = acc + wt(r) * wt(c) * int'(bus.window_out[(r*5+c)*DW +: DW]);
      end
    end
    case (dp_mode)
      0:       bus.conv_in = 24'(acc >> 8);
      1:       bus.conv_in = 24'(bus.window_out[12*DW +: DW]);
      default: bus.conv_in = stub_val;
    endcase
  end

  function automatic logic [7:0] pix(input int pat, input int r, input int c);
    case (pat)
      0:       return 8'd100;
      1:       return 8'(r * 8 + c);
      2:       return (r == 2 && c == 2) ? 8'd255 : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push8(input int a0, input int a1, input int a2, input int a3,
                       input int a4, input int a5, input int a6, input int a7);
    exp_q.push_back(a0); exp_q.push_back(a1); exp_q.push_back(a2); exp_q.push_back(a3);
    exp_q.push_back(a4); exp_q.push_back(a5); exp_q.push_back(a6); exp_q.push_back(a7);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_pixel(input logic [7:0] d);
    int guard;
    bit ok;
    guard = 0;
    ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    do begin
      @(negedge clk);
      ok = bus.s_ready;
      @(posedge clk); #1;
      guard++;
    end while (!ok && guard < 200);
    if (!ok) check("s_ready_timeout", 0, 1);
    bus.s_valid = 1'b0;
  endtask

  task automatic run_frame(input int pat, input bit poke_start);
    int fd0;
    int guard;
    fd0 = fd_cnt;
    out_in_frame = 0;
    pulse_start();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send_pixel(pix(pat, r, c));
        if (poke_start && r == 1 && c == 3) pulse_start();
      end
    end
    guard = 0;
    while (fd_cnt == fd0 && guard < 300) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("frame_done_pulses", fd_cnt - fd0, 1);
    check("outputs_remaining", exp_q.size(), 0);
    check("busy_after_frame", int'(busy), 0);
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
    fork
      begin : monitor
        int e;
        forever begin
          @(negedge clk);
          if (!rst_n) begin
            pend_done = 1'b0;
          end else begin
            if (pend_done) begin
              check("frame_done_after_last", int'(frame_done), 1);
              check("busy_falls_with_done", int'(busy), 0);
              pend_done = 1'b0;
            end
            if (frame_done) fd_cnt++;
            if (bus.m_valid && !bus.m_ready) check("s_ready_in_stall", int'(bus.s_ready), 0);
            if (bus.m_valid && bus.m_ready) begin
              if (exp_q.size() == 0) begin
                check("unexpected_output", int'(bus.m_data), -1);
              end else begin
                e = exp_q.pop_front();
                check("m_data", int'(bus.m_data), e);
              end
              out_in_frame++;
              if (out_in_frame == (W - 4) * (H - 4)) pend_done = 1'b1;
            end
          end
        end
      end
      begin : ready_drv
        forever begin
          @(posedge clk); #1;
          bus.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
      end
      begin : watchdog
        #500000;
        check("global_timeout", 0, 1);
      end
      begin : stim
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_s_ready", int'(bus.s_ready), 0);
        check("rst_m_valid", int'(bus.m_valid), 0);
        check("rst_m_data", int'(bus.m_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Input is not accepted while idle
        bus.s_valid = 1'b1;
        bus.s_data  = 8'd77;
        repeat (3) begin
          @(negedge clk);
          check("idle_s_ready", int'(bus.s_ready), 0);
        end
        @(posedge clk); #1;
        bus.s_valid = 1'b0;

        // Flat field through the Gaussian
        dp_mode = 0;
        push8(100, 100, 100, 100, 100, 100, 100, 100);
        run_frame(0, 1'b0);

        // Ramp through a centre-returning datapath
        dp_mode = 1;
        push8(18, 19, 20, 21, 26, 27, 28, 29);
        run_frame(1, 1'b0);

        // Impulse response of the Gaussian
        dp_mode = 0;
        push8(35, 23, 5, 0, 23, 15, 3, 0);
        run_frame(2, 1'b0);

        // Saturation with a constant stub
        dp_mode = 2;
        stub_val = 24'h000300;
        push8(255, 255, 255, 255, 255, 255, 255, 255);
        run_frame(3, 1'b0);
        stub_val = 24'h0000FF;
        push8(255, 255, 255, 255, 255, 255, 255, 255);
        run_frame(3, 1'b0);
        stub_val = 24'h010000;
        push8(255, 255, 255, 255, 255, 255, 255, 255);
        run_frame(3, 1'b0);
        stub_val = 24'h00007F;
        push8(127, 127, 127, 127, 127, 127, 127, 127);
        run_frame(3, 1'b0);

        // Ramp through the Gaussian with random backpressure
        dp_mode = 0;
        rand_ready = 1'b1;
        push8(18, 19, 20, 21, 26, 27, 28, 29);
        run_frame(1, 1'b0);
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset after 20 accepts, then a full frame with a start poke mid-run
        dp_mode = 1;
        out_in_frame = 0;
        pulse_start();
        for (int i = 0; i < 20; i++) send_pixel(pix(1, i / W, i % W));
        @(negedge clk);
        check("busy_mid_frame", int'(busy), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_s_ready", int'(bus.s_ready), 0);
        check("midrst_m_valid", int'(bus.m_valid), 0);
        check("midrst_m_data", int'(bus.m_data), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_frame_done", int'(frame_done), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        push8(18, 19, 20, 21, 26, 27, 28, 29);
        run_frame(1, 1'b1);
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gauss5_window_ctrl.md
Name: gauss5_window_ctrl

Overview:
- Sequences the combinational 5x5 Gaussian convolution datapath for a raster pixel stream.
- Accepts pixels over valid/ready and builds the 5x5 window with 4 line buffers and a 5x5 shift array.
- Drives the window to the external convolution datapath, captures its 24-bit result and emits a saturated 8-bit filtered pixel over valid/ready.
- Frame control: start pulse in, done pulse out; output covers the valid (interior) region only.

Parameters:
- DATA_WIDTH, 8, pixel width.
- IMG_W, 640, pixels per line (legal range 5..4096).
- IMG_H, 480, lines per frame (legal range 5..4096).

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  one-cycle pulse; arms a frame (ignored unless IDLE)
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel accepted when s_valid&&s_ready
- s_data  in  DATA_WIDTH  input pixel, raster order
- window_out  out  25*DATA_WIDTH  window to datapath; element k at bits [k*DATA_WIDTH +: DATA_WIDTH], k=row*5+col, row 0 oldest line, col 0 oldest pixel
- conv_in  in  24  datapath result for current window_out (combinational return)
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream ready
- m_data  out  DATA_WIDTH  filtered pixel
- busy  out  1  high in RUN
- frame_done  out  1  one-cycle pulse after last output pixel accepted

Behaviour:
- Reset (async, rst_n low): state=IDLE, s_ready=0, m_valid=0, m_data=0, busy=0, frame_done=0, counters=0, win_vld=0; window and line buffers need not be cleared.
- FSM: IDLE -start-> RUN; RUN -last output handshake-> DONE; DONE -> IDLE unconditionally (frame_done=1 during DONE only).
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance per accepted input; col wraps to 0 and row increments at IMG_W-1.
- Pipeline advance: adv = !m_valid || m_ready. s_ready = (state==RUN) && adv && !in_all, where in_all is set after pixel (IMG_H-1, IMG_W-1) is accepted and cleared on IDLE.
- On accept: shift the window array one column left; the new right column is {linebuf3..linebuf0 at col, s_data}. Line buffers are written with the shifted data at col. win_vld is registered as (row>=4 && col>=4); it is cleared on an adv cycle without accept.
- Output stage: on adv with win_vld=1, m_valid<=1 and m_data<=sat(conv_in); on adv with win_vld=0, m_valid<=0. sat: conv_in>255 (any of bits [23:8] set) gives 255, else conv_in[7:0].
- Latency: the accept of pixel (r,c) gives the window centred at (r-2,c-2). m_valid rises 2 clk later when there is no backpressure.
- Output count per frame: (IMG_W-4)*(IMG_H-4), raster order. Windows that straddle a line wrap (col<4) never produce output.
- Backpressure: while m_valid&&!m_ready, window, win_vld, m_data and counters hold, and s_ready=0. No data loss or duplication.
- Start during RUN or DONE is ignored. s_valid in IDLE is not accepted.
- Reset mid-frame: immediate return to IDLE, partial frame discarded. The next start begins at row=col=0.
- conv_in is assumed combinational from window_out within one cycle. This block adds no delay compensation.

Optional Feature:
- Macro CONV_BYPASS_EN adds an input port bypass (1 bit).
- With the macro and bypass=1: m_data captures the window centre element (k=12) instead of sat(conv_in). Timing, counts and handshakes are unchanged.
- bypass is sampled per output capture, so it may change mid-frame.
- Without the macro: the port is absent and conv_in is always used.

Test Plan:
- IMG_W=8, IMG_H=6, constant pixel 100, true Gaussian datapath, m_ready=1 -> exactly 8 outputs, all 100. frame_done pulses once, 1 cycle after the 8th output. busy falls with it.
- Ramp s_data=row*8+col, bypass model returning window centre -> outputs 18,19,20,21,26,27,28,29 in order.
- Single 255 at (2,2), zero elsewhere -> first output (centre 2,2) equals 36*255/256 = 35. All other outputs are 0 or the matching kernel weights.
- Datapath stub forces conv_in=24'h000300 -> m_data=255 (saturation). conv_in=24'h0000FF -> 255. conv_in=24'h00007F -> 127.
- m_ready toggling pseudo-randomly at 50% -> output sequence matches the no-stall run. s_ready=0 whenever m_valid&&!m_ready.
- rst_n low for 1 cycle mid-frame after 20 accepts -> all outputs reset to 0. A new start with a full frame yields the correct 8 outputs. A start pulse issued during RUN is ignored.
